// File: rtl/ext_input_conditioner_if.sv
// Button/status bundle between the raw button pins, software clear strobe and
// the conditioned status word consumed by the register file.
interface ext_input_conditioner_if #(
  parameter int N_BTN = 8
);
  logic [N_BTN-1:0] raw_buttons;
  logic             clear_events;
  logic [31:0]      external_inputs;

  modport master (
    output raw_buttons,
    output clear_events,
    input  external_inputs
  );

  modport slave (
    input  raw_buttons,
    input  clear_events,
    output external_inputs
  );
endinterface

// File: rtl/ext_input_conditioner.sv
// Synchronizes, debounces and edge-detects the raw buttons, keeps sticky press
// flags plus a saturating press count, and packs everything into one status word.
module ext_input_conditioner #(
  parameter int N_BTN           = 8,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CNT_W           = 16
) (
  input logic                   clock,
  input logic                   ctrl_reset,
  ext_input_conditioner_if.slave bus
);

  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] DB_FULL = CNT_W'(DEBOUNCE_CYCLES);

  logic [N_BTN-1:0] sync1, sync2;
  logic [N_BTN-1:0] stable, stable_next;
  logic [N_BTN-1:0] rise;
  logic [N_BTN-1:0] flags;
  logic [CNT_W-1:0] cnt      [N_BTN];
  logic [CNT_W-1:0] cnt_next [N_BTN];
  logic [7:0]       count, count_next;
  logic [3:0]       rise_pop;
  logic [7:0]       count_base;
  logic [9:0]       count_sum;
  logic [CNT_W-1:0] settle;
  logic             ready;
  logic [7:0]       stable_ext, flags_ext;
  logic [31:0]      word;

  always_comb begin
    for (int i = 0; i < N_BTN; i++) begin
      stable_next[i] = stable[i];
      cnt_next[i]    = cnt[i];
      if (sync2[i] == stable[i]) begin
        cnt_next[i] = '0;
      end else if (cnt[i] == DB_LAST) begin
        stable_next[i] = sync2[i];
        cnt_next[i]    = '0;
      end else begin
        cnt_next[i] = cnt[i] + 1'b1;
      end
    end
  end

  // Presses are judged on the level being committed this edge, so flags and
  // count update on the same edge as the stable level itself.
  always_comb begin
    rise     = stable_next & ~stable;
    rise_pop = '0;
    for (int i = 0; i < N_BTN; i++) begin
      rise_pop = rise_pop + 4'(rise[i]);
    end
    count_base = bus.clear_events ? 8'h00 : count;
    count_sum  = {2'b00, count_base} + {6'b000000, rise_pop};
    count_next = (count_sum > 10'd255) ? 8'hFF : count_sum[7:0];
  end

  always_comb begin
    stable_ext = '0;
    flags_ext  = '0;
    stable_ext[N_BTN-1:0] = stable;
    flags_ext[N_BTN-1:0]  = flags;
  end

  always_ff @(posedge clock) begin
    if (!ctrl_reset) begin
      sync1  <= '0;
      sync2  <= '0;
      stable <= '0;
      flags  <= '0;
      count  <= '0;
      settle <= '0;
      ready  <= 1'b0;
      word   <= '0;
      for (int i = 0; i < N_BTN; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      sync1  <= bus.raw_buttons;
      sync2  <= sync1;
      stable <= stable_next;
      flags  <= (flags & ~{N_BTN{bus.clear_events}}) | rise;
      count  <= count_next;
      for (int i = 0; i < N_BTN; i++) begin
        cnt[i] <= cnt_next[i];
      end
      if (settle != DB_FULL) begin
        settle <= settle + 1'b1;
        if (settle == DB_LAST) begin
          ready <= 1'b1;
        end
      end
      word <= {ready, 7'b0000000, count, flags_ext, stable_ext};
    end
  end

  assign bus.external_inputs = word;

endmodule

// File: tb/tb_ext_input_conditioner.sv
// Randomized and directed bench for ext_input_conditioner with a window-based
// reference model compared against the status word on every cycle.
module tb_ext_input_conditioner;

  localparam int N_BTN = 8;
  localparam int DB    = 4;

  logic clock;
  logic ctrl_reset;

  ext_input_conditioner_if #(.N_BTN(N_BTN)) bus ();

  ext_input_conditioner #(
    .N_BTN(N_BTN),
    .DEBOUNCE_CYCLES(DB),
    .CNT_W(16)
  ) dut (
    .clock(clock),
    .ctrl_reset(ctrl_reset),
    .bus(bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a button flips once its debouncer input has shown the
  // opposite level on each of the last DB edges, all taken after its previous flip.
  bit          m_valid = 0;
  int          edge_no = 0;
  logic [7:0]  p1, p2, m_stable, m_flags, m_din, m_rise, m_nstable;
  int          m_count;
  int          since_rel;
  int          last_flip [N_BTN];
  logic [7:0]  din_q [$];
  logic [31:0] m_word;
  bit          all_diff;

  always @(posedge clock) begin
    if (!ctrl_reset) begin
      m_word    = '0;
      p1        = '0;
      p2        = '0;
      m_stable  = '0;
      m_flags   = '0;
      m_count   = 0;
      since_rel = 0;
      din_q.delete();
      for (int i = 0; i < N_BTN; i++) last_flip[i] = edge_no;
      m_valid = 1;
    end else if (m_valid) begin
      m_word = {(since_rel >= DB) ? 1'b1 : 1'b0, 7'b0, 8'(m_count), m_flags, m_stable};
      m_din = p2;
      p2 = p1;
      p1 = bus.raw_buttons;
      din_q.push_back(m_din);
      if (din_q.size() > DB) void'(din_q.pop_front());
      m_nstable = m_stable;
      for (int i = 0; i < N_BTN; i++) begin
        all_diff = (edge_no - last_flip[i] >= DB) && (din_q.size() == DB);
        foreach (din_q[k]) if (din_q[k][i] == m_stable[i]) all_diff = 0;
        if (all_diff) begin
          m_nstable[i] = ~m_stable[i];
          last_flip[i] = edge_no;
        end
      end
      m_rise  = m_nstable & ~m_stable;
      m_count = (bus.clear_events ? 0 : m_count) + $countones(m_rise);
      if (m_count > 255) m_count = 255;
      m_flags  = (bus.clear_events ? 8'h00 : m_flags) | m_rise;
      m_stable = m_nstable;
      if (since_rel < 1000) since_rel++;
    end
    edge_no++;
  end

  always @(negedge clock) begin
    if (m_valid) check_output("model_word", bus.external_inputs, m_word);
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  // Holds a raw pattern for a number of cycles, strobing clear at random.
  task automatic apply_stimulus(input logic [7:0] raw, input int cycles, input bit rand_clear);
    bus.raw_buttons = raw;
    for (int c = 0; c < cycles; c++) begin
      bus.clear_events = rand_clear && ($urandom_range(0, 5) == 0);
      tick(1);
    end
    bus.clear_events = 1'b0;
  endtask

  initial begin
    ctrl_reset       = 1'b0;
    bus.raw_buttons  = '0;
    bus.clear_events = 1'b0;
    tick(3);
    check_output("reset_word", bus.external_inputs, 32'h0);

    ctrl_reset = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      tick(1);
      check_output("ready_settle", bus.external_inputs, (k < 5) ? 32'h0 : 32'h8000_0000);
    end

    bus.raw_buttons = 8'h04;
    tick(6);
    check_output("press2_early", bus.external_inputs, 32'h8000_0000);
    tick(1);
    check_output("press2_edge7", bus.external_inputs, 32'h8001_0404);

    bus.raw_buttons = 8'h05;
    tick(3);
    bus.raw_buttons = 8'h04;
    tick(10);
    check_output("glitch_reject", bus.external_inputs, 32'h8001_0404);

    bus.raw_buttons = 8'h0E;
    tick(6);
    check_output("dual_early", bus.external_inputs, 32'h8001_0404);
    tick(1);
    check_output("dual_press", bus.external_inputs, 32'h8003_0E0E);
    bus.raw_buttons = 8'h0C;
    tick(8);
    check_output("release1", bus.external_inputs, 32'h8003_0E0C);
    bus.raw_buttons = 8'h0E;
    tick(8);
    check_output("repress1", bus.external_inputs, 32'h8004_0E0E);

    bus.raw_buttons = 8'h2E;
    tick(5);
    bus.clear_events = 1'b1;
    tick(1);
    bus.clear_events = 1'b0;
    tick(1);
    check_output("clear_with_rise", bus.external_inputs, 32'h8001_202E);

    for (int n = 0; n < 260; n++) begin
      bus.raw_buttons = 8'h3E;
      tick(8);
      bus.raw_buttons = 8'h2E;
      tick(8);
    end
    check_output("count_saturate", bus.external_inputs, 32'h80FF_302E);

    bus.raw_buttons = 8'h6E;
    tick(2);
    ctrl_reset = 1'b0;
    bus.clear_events = 1'b1;
    tick(1);
    bus.clear_events = 1'b0;
    check_output("mid_reset", bus.external_inputs, 32'h0);
    ctrl_reset = 1'b1;
    tick(4);
    check_output("resettle_quiet", bus.external_inputs, 32'h0);
    tick(1);
    check_output("resettle_ready", bus.external_inputs, 32'h8000_0000);
    tick(2);
    check_output("resettle_levels", bus.external_inputs, 32'h8005_6E6E);

    for (int n = 0; n < 300; n++) begin
      apply_stimulus(8'($urandom), $urandom_range(1, 9), 1'b1);
    end
    apply_stimulus(8'h00, 12, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
